// File: rtl/axi_burst_fifo.sv
// axi_burst_fifo: burst-aware valid/ready channel buffer with store-and-forward or cut-through release.
// Define AXI_BURST_FIFO_STATS_EN to add the stall_cnt / hwm / burst_cnt statistics outputs.
module axi_burst_fifo #(
   parameter int DATA_W       = 576,
   parameter int DEPTH        = 64,
   parameter int STORE_FWD    = 1,
   parameter int AFULL_THRESH = DEPTH - 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic [DATA_W-1:0]          s_data,
   input  logic                       s_last,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [DATA_W-1:0]          m_data,
   output logic                       m_last,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic [$clog2(DEPTH+1)-1:0] bursts,
   output logic                       almost_full,
   output logic                       sf_overflow
`ifdef AXI_BURST_FIFO_STATS_EN
   ,
   output logic [31:0]                stall_cnt,
   output logic [$clog2(DEPTH+1)-1:0] hwm,
   output logic [31:0]                burst_cnt
`endif
);

   // state   | meaning
   // ST_HEAD | next beat to load starts a burst; held back in store-and-forward mode
   // ST_BODY | next beat continues a burst already started downstream; never held back

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_C = CW'(AFULL_THRESH);
   localparam bit SF = (STORE_FWD != 0);

   typedef enum logic {ST_HEAD, ST_BODY} state_t;

   logic [DATA_W:0] mem [DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr, rd_ptr_next;
   logic [CW-1:0]   count_next, bursts_next;
   logic            push, pop, push_last, pop_last;
   logic            avail, full_release, load;
   state_t          state, state_next;

   assign push      = s_valid && s_ready;
   assign pop       = m_valid && m_ready;
   assign push_last = push && s_last;
   assign pop_last  = pop && m_last;

   // The output stage mirrors mem[rd_ptr]; the RAM slot is only freed when the beat is popped.
   assign rd_ptr_next  = pop ? rd_ptr + PW'(1) : rd_ptr;
   assign avail        = (rd_ptr_next != wr_ptr);
   assign full_release = SF && (count == FULL_C) && (bursts == '0);

   always_comb begin
      count_next = count;
      if (push && !pop)
         count_next = count + CW'(1);
      else if (pop && !push)
         count_next = count - CW'(1);
   end

   always_comb begin
      bursts_next = bursts;
      if (push_last && !pop_last)
         bursts_next = bursts + CW'(1);
      else if (pop_last && !push_last)
         bursts_next = bursts - CW'(1);
   end

   // Bursts complete in order, so any complete burst held implies the head burst is complete.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      if (pop)
         state_next = m_last ? ST_HEAD : ST_BODY;
      if ((!m_valid || pop) && avail) begin
         if (!SF || (state_next == ST_BODY) || (bursts_next != '0) || full_release)
            load = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ST_HEAD;
      else
         state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr[AW-1:0]] <= {s_last, s_data};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         bursts      <= '0;
         s_ready     <= 1'b0;
         almost_full <= 1'b0;
         sf_overflow <= 1'b0;
         m_valid     <= 1'b0;
         m_data      <= '0;
         m_last      <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         rd_ptr      <= rd_ptr_next;
         count       <= count_next;
         bursts      <= bursts_next;
         s_ready     <= (count_next < FULL_C);
         almost_full <= (count_next >= AFULL_C);
         if (full_release)
            sf_overflow <= 1'b1;
         if (load) begin
            {m_last, m_data} <= mem[rd_ptr_next[AW-1:0]];
            m_valid          <= 1'b1;
         end else if (pop) begin
            m_valid <= 1'b0;
         end
      end
   end

`ifdef AXI_BURST_FIFO_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         hwm       <= '0;
         burst_cnt <= '0;
      end else begin
         if (s_valid && !s_ready && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 32'd1;
         if (pop_last && (burst_cnt != '1))
            burst_cnt <= burst_cnt + 32'd1;
         if (count_next > hwm)
            hwm <= count_next;
      end
   end
`endif

endmodule

// File: tb/tb_axi_burst_fifo.sv
// Directed bench for axi_burst_fifo: one store-and-forward and one cut-through instance,
// with a per-instance scoreboard of accepted beats checked against every downstream pop.
module tb_axi_burst_fifo;
   localparam int DW    = 32;
   localparam int DEPTH = 64;
   localparam int CW    = $clog2(DEPTH + 1);

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   logic          sf_s_valid, sf_s_ready, sf_s_last, sf_m_valid, sf_m_ready, sf_m_last;
   logic [DW-1:0] sf_s_data, sf_m_data;
   logic [CW-1:0] sf_count, sf_bursts;
   logic          sf_afull, sf_ovf;
   logic          ct_s_valid, ct_s_ready, ct_s_last, ct_m_valid, ct_m_ready, ct_m_last;
   logic [DW-1:0] ct_s_data, ct_m_data;
   logic [CW-1:0] ct_count, ct_bursts;
   logic          ct_afull, ct_ovf;
`ifdef AXI_BURST_FIFO_STATS_EN
   logic [31:0]   sf_stall, sf_bcnt, ct_stall, ct_bcnt;
   logic [CW-1:0] sf_hwm, ct_hwm;
`endif

   int tests   = 0;
   int fails   = 0;
   int sf_pops = 0;
   int ct_pops = 0;
   int base;
   logic [DW:0] sf_q[$];
   logic [DW:0] ct_q[$];

   always #5 clk = ~clk;

   axi_burst_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .STORE_FWD(1)) u_sf (
      .clk(clk), .rst_n(rst_n),
      .s_valid(sf_s_valid), .s_ready(sf_s_ready), .s_data(sf_s_data), .s_last(sf_s_last),
      .m_valid(sf_m_valid), .m_ready(sf_m_ready), .m_data(sf_m_data), .m_last(sf_m_last),
      .count(sf_count), .bursts(sf_bursts), .almost_full(sf_afull), .sf_overflow(sf_ovf)
`ifdef AXI_BURST_FIFO_STATS_EN
      , .stall_cnt(sf_stall), .hwm(sf_hwm), .burst_cnt(sf_bcnt)
`endif
   );

   axi_burst_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .STORE_FWD(0)) u_ct (
      .clk(clk), .rst_n(rst_n),
      .s_valid(ct_s_valid), .s_ready(ct_s_ready), .s_data(ct_s_data), .s_last(ct_s_last),
      .m_valid(ct_m_valid), .m_ready(ct_m_ready), .m_data(ct_m_data), .m_last(ct_m_last),
      .count(ct_count), .bursts(ct_bursts), .almost_full(ct_afull), .sf_overflow(ct_ovf)
`ifdef AXI_BURST_FIFO_STATS_EN
      , .stall_cnt(ct_stall), .hwm(ct_hwm), .burst_cnt(ct_bcnt)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Handshakes are judged at the falling edge, ahead of the rising edge that completes them.
   task automatic tick();
      logic [DW:0] exp_b;
      @(negedge clk);
      if (sf_m_valid && sf_m_ready) begin
         sf_pops++;
         exp_b = (sf_q.size() != 0) ? sf_q.pop_front() : 'x;
         chk("sf_pop_beat", 64'({sf_m_last, sf_m_data}), 64'(exp_b));
      end
      if (ct_m_valid && ct_m_ready) begin
         ct_pops++;
         exp_b = (ct_q.size() != 0) ? ct_q.pop_front() : 'x;
         chk("ct_pop_beat", 64'({ct_m_last, ct_m_data}), 64'(exp_b));
      end
      if (sf_s_valid && sf_s_ready) sf_q.push_back({sf_s_last, sf_s_data});
      if (ct_s_valid && ct_s_ready) ct_q.push_back({ct_s_last, ct_s_data});
      @(posedge clk);
      #1;
   endtask

   initial begin
      sf_s_valid = 0; sf_s_data = '0; sf_s_last = 0; sf_m_ready = 0;
      ct_s_valid = 0; ct_s_data = '0; ct_s_last = 0; ct_m_ready = 0;

      // reset then idle
      repeat (5) @(posedge clk);
      #1;
      chk("rst_sf_s_ready", 64'(sf_s_ready), 64'(0));
      chk("rst_ct_s_ready", 64'(ct_s_ready), 64'(0));
      chk("rst_sf_m_valid", 64'(sf_m_valid), 64'(0));
      chk("rst_sf_count", 64'(sf_count), 64'(0));
      rst_n = 1'b1;
      tick();
      chk("rel_sf_s_ready", 64'(sf_s_ready), 64'(1));
      chk("rel_ct_s_ready", 64'(ct_s_ready), 64'(1));
      chk("rel_ct_m_valid", 64'(ct_m_valid), 64'(0));

      // store-and-forward gating: 8-beat burst
      sf_m_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         chk("sf_gate_m_valid", 64'(sf_m_valid), 64'(0));
         chk("sf_gate_bursts", 64'(sf_bursts), 64'(0));
         sf_s_valid = 1'b1;
         sf_s_data  = 32'hA000_0000 + 32'(i);
         sf_s_last  = (i == 8);
         tick();
      end
      sf_s_valid = 1'b0;
      sf_s_last  = 1'b0;
      chk("sf_release_m_valid", 64'(sf_m_valid), 64'(1));
      chk("sf_release_bursts", 64'(sf_bursts), 64'(1));
      for (int i = 0; i < 8; i++) begin
         chk("sf_b2b_m_valid", 64'(sf_m_valid), 64'(1));
         tick();
      end
      chk("sf_burst_done_m_valid", 64'(sf_m_valid), 64'(0));
      chk("sf_burst_done_bursts", 64'(sf_bursts), 64'(0));
      chk("sf_burst_done_pops", 64'(sf_pops), 64'(8));
      sf_m_ready = 1'b0;

      // cut-through latency and throughput
      ct_s_valid = 1'b1;
      ct_s_data  = 32'h0000_C0DE;
      ct_s_last  = 1'b1;
      tick();
      ct_s_valid = 1'b0;
      chk("ct_lat_edge_n", 64'(ct_m_valid), 64'(0));
      tick();
      chk("ct_lat_edge_n1", 64'(ct_m_valid), 64'(1));
      ct_m_ready = 1'b1;
      tick();
      base = ct_pops;
      for (int i = 0; i < 100; i++) begin
         ct_s_valid = 1'b1;
         ct_s_data  = $urandom;
         ct_s_last  = ((i % 10) == 9);
         tick();
      end
      chk("ct_throughput", 64'(ct_pops - base), 64'(98));
      ct_s_valid = 1'b0;
      tick();
      tick();
      chk("ct_stream_pops", 64'(ct_pops - base), 64'(100));
      chk("ct_stream_q", 64'(ct_q.size()), 64'(0));
      chk("ct_stream_m_valid", 64'(ct_m_valid), 64'(0));
      ct_m_ready = 1'b0;

      // full boundary with single-beat bursts
      for (int k = 1; k <= DEPTH; k++) begin
         sf_s_valid = 1'b1;
         sf_s_data  = 32'hB000_0000 + 32'(k);
         sf_s_last  = 1'b1;
         tick();
         if (k == 59) chk("full_afull_59", 64'(sf_afull), 64'(0));
         if (k == 60) begin
            chk("full_afull_60", 64'(sf_afull), 64'(1));
            chk("full_count_60", 64'(sf_count), 64'(60));
         end
      end
      chk("full_s_ready", 64'(sf_s_ready), 64'(0));
      chk("full_count", 64'(sf_count), 64'(64));
      chk("full_bursts", 64'(sf_bursts), 64'(64));
      sf_s_data = 32'hDEAD_BEEF;
      tick();
      sf_s_valid = 1'b0;
      chk("full_blocked_count", 64'(sf_count), 64'(64));
      sf_m_ready = 1'b1;
      tick();
      sf_m_ready = 1'b0;
      chk("full_pop_s_ready", 64'(sf_s_ready), 64'(1));
      chk("full_pop_count", 64'(sf_count), 64'(63));
      chk("full_no_ovf", 64'(sf_ovf), 64'(0));
`ifdef AXI_BURST_FIFO_STATS_EN
      chk("stats_stall_1", 64'(sf_stall), 64'(1));
`endif
      sf_m_ready = 1'b1;
      for (int k = 0; k < 200 && sf_count != 0; k++) tick();
      sf_m_ready = 1'b0;
      chk("full_drain_count", 64'(sf_count), 64'(0));
      chk("full_drain_q", 64'(sf_q.size()), 64'(0));

      // deadlock release: 64 beats without a last
      for (int k = 1; k <= DEPTH; k++) begin
         sf_s_valid = 1'b1;
         sf_s_data  = 32'hD000_0000 + 32'(k);
         sf_s_last  = 1'b0;
         tick();
      end
      chk("dl_count", 64'(sf_count), 64'(64));
      chk("dl_bursts", 64'(sf_bursts), 64'(0));
      chk("dl_m_valid_pre", 64'(sf_m_valid), 64'(0));
      chk("dl_ovf_pre", 64'(sf_ovf), 64'(0));
      tick();
      sf_s_valid = 1'b0;
      chk("dl_m_valid", 64'(sf_m_valid), 64'(1));
      chk("dl_ovf", 64'(sf_ovf), 64'(1));
      chk("dl_count_hold", 64'(sf_count), 64'(64));
      sf_m_ready = 1'b1;
      for (int k = 0; k < 200 && sf_count != 0; k++) tick();
      sf_m_ready = 1'b0;
      chk("dl_drain_count", 64'(sf_count), 64'(0));
      chk("dl_drain_q", 64'(sf_q.size()), 64'(0));
      chk("dl_ovf_sticky", 64'(sf_ovf), 64'(1));
      chk("ct_no_ovf", 64'(ct_ovf), 64'(0));

      // reset mid-burst
      for (int k = 1; k <= 5; k++) begin
         sf_s_valid = 1'b1;
         sf_s_data  = 32'hE000_0000 + 32'(k);
         sf_s_last  = 1'b0;
         tick();
      end
      sf_s_valid = 1'b0;
      chk("mid_count_pre", 64'(sf_count), 64'(5));
`ifdef AXI_BURST_FIFO_STATS_EN
      chk("stats_hwm_pre", 64'(sf_hwm), 64'(64));
      chk("stats_stall_pre", 64'(sf_stall), 64'(2));
      chk("stats_bcnt_pre", 64'(sf_bcnt), 64'(65));
`endif
      rst_n = 1'b0;
      #1;
      chk("mid_rst_count", 64'(sf_count), 64'(0));
      chk("mid_rst_m_valid", 64'(sf_m_valid), 64'(0));
      chk("mid_rst_s_ready", 64'(sf_s_ready), 64'(0));
      chk("mid_rst_ovf", 64'(sf_ovf), 64'(0));
      chk("mid_rst_bursts", 64'(sf_bursts), 64'(0));
`ifdef AXI_BURST_FIFO_STATS_EN
      chk("mid_rst_hwm", 64'(sf_hwm), 64'(0));
      chk("mid_rst_stall", 64'(sf_stall), 64'(0));
      chk("mid_rst_bcnt", 64'(sf_bcnt), 64'(0));
`endif
      sf_q.delete();
      ct_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      chk("post_rst_s_ready", 64'(sf_s_ready), 64'(1));
      sf_s_valid = 1'b1;
      sf_s_data  = 32'h0000_5EED;
      sf_s_last  = 1'b1;
      tick();
      sf_s_valid = 1'b0;
      chk("post_rst_lat", 64'(sf_m_valid), 64'(0));
      tick();
      chk("post_rst_m_valid", 64'(sf_m_valid), 64'(1));
      base = sf_pops;
      sf_m_ready = 1'b1;
      tick();
      sf_m_ready = 1'b0;
      chk("post_rst_pops", 64'(sf_pops - base), 64'(1));
      chk("post_rst_count", 64'(sf_count), 64'(0));
      chk("post_rst_q", 64'(sf_q.size()), 64'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/axi_burst_fifo.md
Name: axi_burst_fifo

Overview:
- Parametrised, burst-aware buffer for one AXI channel (W, R, or any valid/ready channel with a LAST bit). Payload width, depth and forwarding mode are generics.
- Sits between a CL master and the DDR/PCIS AXI fabric, one instance per channel.
- In store-and-forward mode, a burst is presented downstream only once its last beat is buffered, so W bursts never stall the interconnect mid-burst.

Parameters:
- DATA_W, 576, payload width in bits, excluding LAST (512 data + 64 strobe for W).
- DEPTH, 64, entry count; power of 2, at least 4.
- STORE_FWD, 1: 1 = release only complete bursts; 0 = cut-through, first-word fall-through.
- AFULL_THRESH, DEPTH-4, count at or above which almost_full asserts.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  upstream beat valid.
- s_ready  out  1  upstream ready; registered.
- s_data  in  DATA_W  upstream payload.
- s_last  in  1  upstream last beat of burst.
- m_valid  out  1  downstream beat valid.
- m_ready  in  1  downstream ready.
- m_data  out  DATA_W  downstream payload.
- m_last  out  1  downstream last beat.
- count  out  $clog2(DEPTH+1)  entries held.
- bursts  out  $clog2(DEPTH+1)  complete bursts held (last beat stored, not yet popped).
- almost_full  out  1  count >= AFULL_THRESH; registered.
- sf_overflow  out  1  sticky: full with no complete burst in store-and-forward mode.

Behaviour:
- Reset (rst_n low, asynchronous): the pointers, count, bursts, sf_overflow and almost_full all clear. s_ready = 0, m_valid = 0, m_data and m_last = 0.
- First rising edge after rst_n deasserts: s_ready rises to 1.
- Reset mid-burst discards all buffered beats, including partial bursts.
- Push occurs when s_valid && s_ready. Pop occurs when m_valid && m_ready.
- s_ready is registered and equals (count_next < DEPTH). There is no combinational path from m_ready to s_ready.
- Because s_ready is registered, a push is never accepted while full, even if a pop happens in the same cycle.
- Storage is a dual-pointer RAM with a registered output stage.
- Latency: a beat pushed at edge N is visible on m_data/m_valid after edge N+1 at the earliest (1-cycle min latency).
- Push and pop in the same cycle when the FIFO is empty: the new beat is not visible that cycle.
- Sustained throughput is 1 beat/clk with simultaneous push and pop.
- m_valid, once asserted, holds, and m_data/m_last stay stable until the pop (AXI rule).
- count arithmetic: +1 on push only, -1 on pop only, unchanged on both.
- bursts arithmetic: +1 on push with s_last, -1 on pop with m_last, unchanged on both.
- Pointers are $clog2(DEPTH)+1 bits; wrap-around is natural modulo, and full/empty are distinguished by the MSB.
- STORE_FWD=0: m_valid asserts whenever count > 0, subject to the output-stage latency.
- STORE_FWD=1:
  - When the head beat belongs to a new burst, m_valid asserts only when bursts > 0, or when the full-release condition below applies.
  - Once the first beat of a burst is popped, the remaining beats of that burst stream without gating.
  - Full-release: if count == DEPTH and bursts == 0, forward anyway (cut-through) to avoid deadlock, and set sf_overflow.
  - sf_overflow stays 1 until reset.
  - sf_overflow is always 0 when STORE_FWD=0.
- Single-beat bursts (s_last on every beat) are legal; bursts can increment every cycle.
- almost_full is registered from count_next.

Optional Feature:
- Macro: AXI_BURST_FIFO_STATS_EN.
- Defined: adds three outputs.
  - stall_cnt, out, 32: cycles with s_valid && !s_ready.
  - hwm, out, $clog2(DEPTH+1): maximum count seen since reset.
  - burst_cnt, out, 32: bursts popped.
- All three clear on reset. stall_cnt and burst_cnt saturate at all-ones.
- Not defined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
1. Reset then idle: hold rst_n low for 5 clk, release. Required: s_ready = 0 during reset and = 1 one clk after release; m_valid = 0; count = 0.
2. Store-and-forward gating (STORE_FWD=1, DEPTH=64): push 8 beats, s_last on beat 8, m_ready = 1. Required: m_valid = 0 until the beat-8 push, then 8 back-to-back beats with m_last on the 8th; bursts goes 0 -> 1 -> 0.
3. Cut-through (STORE_FWD=0): push 1 beat at edge N. Required: m_valid high after edge N+1; stream 100 beats with m_ready = 1 -> 1 beat/clk, data in order.
4. Full boundary: hold m_ready = 0 and push 64 single-beat bursts. Required: s_ready = 0 after the 64th push; almost_full from count 60; one pop -> s_ready = 1 the next clk; count = 63.
5. Deadlock release: STORE_FWD=1, push 64 beats with no s_last. Required: sf_overflow = 1; m_valid = 1; beats drain in order; sf_overflow stays 1 until rst_n pulse.
6. Reset mid-burst and stats: with AXI_BURST_FIFO_STATS_EN, push 5 beats, assert rst_n low. Required: count = 0, m_valid = 0, hwm = 0, stall_cnt = 0 immediately (asynchronous).
